// File: rtl/mem_wb_ctrl_pkg.sv
// Shared encodings for the MEM/WB sequencer: FSM states and mem_to_reg select values.
package mem_wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WB   = 2'd2
  } state_e;

  localparam logic SEL_ALU = 1'b0;
  localparam logic SEL_MEM = 1'b1;

endpackage

// File: rtl/mem_wb_ctrl_if.sv
// Data-memory req/ack bus between the MEM-stage controller (master) and the memory (slave).
interface mem_wb_ctrl_if #(parameter int XLEN = 32);
  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic            mem_ack;
  logic [XLEN-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_wb_ctrl_req_timer.sv
// Counts REQ cycles without an ack; expired flags the last cycle before the request is abandoned.
module req_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [7:0] TC = 8'(TIMEOUT - 1);

  logic [7:0] count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= 8'd0;
    end else if (en) begin
      count <= count + 8'd1;
    end
  end

  assign expired = (count == TC);

endmodule

// File: rtl/mem_wb_ctrl.sv
// MEM/WB stage sequencer: issues load/store requests to a variable-latency memory,
// stalls upstream while a request is outstanding and drives the register-file write port.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no request outstanding; accepts ALU ops and memory ops
// ST_REQ  | mem_req held high, waiting for mem_ack or timeout
// ST_WB   | load writeback cycle; accepts a new op exactly like IDLE
module mem_wb_ctrl
  import mem_wb_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid_in,
  input  logic                is_load,
  input  logic                is_store,
  input  logic                reg_write_in,
  input  logic [4:0]          rd_in,
  input  logic [XLEN-1:0]     alu_result,
  input  logic [XLEN-1:0]     store_data,
  mem_wb_ctrl_if.master       mem,
  output logic                stall,
  output logic                mem_to_reg,
  output logic [XLEN-1:0]     alu_q,
  output logic [XLEN-1:0]     ld_q,
  output logic                wb_en,
  output logic [4:0]          wb_rd,
  output logic                mem_err
);

  state_e     state;
  logic [4:0] rd_q;
  logic       rw_q;
  logic       mem_op;
  logic       accept;
  logic       expired;
  logic       alu_wr;
  logic       ld_wr;

  assign mem_op = is_load | is_store;
  assign accept = (state != ST_REQ) && valid_in && mem_op;
  assign stall  = !rst && ((state == ST_REQ) || accept);
  assign alu_wr = reg_write_in && (rd_in != 5'd0);
  assign ld_wr  = rw_q && (rd_q != 5'd0);

  req_timer #(.TIMEOUT(TIMEOUT)) u_req_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (state != ST_REQ),
    .en      ((state == ST_REQ) && !mem.mem_ack),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      rd_q          <= 5'd0;
      rw_q          <= 1'b0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
      mem_to_reg    <= SEL_ALU;
      alu_q         <= '0;
      ld_q          <= '0;
      wb_en         <= 1'b0;
      wb_rd         <= 5'd0;
      mem_err       <= 1'b0;
    end else begin
      wb_en   <= 1'b0;
      mem_err <= 1'b0;
      case (state)
        ST_REQ: begin
          if (mem.mem_ack) begin
            mem.mem_req <= 1'b0;
            if (!mem.mem_we) begin
              ld_q  <= mem.mem_rdata;
              wb_en <= ld_wr;
              wb_rd <= rd_q;
              if (ld_wr) mem_to_reg <= SEL_MEM;
              state <= ST_WB;
            end else begin
              state <= ST_IDLE;
            end
          end else if (expired) begin
            mem.mem_req <= 1'b0;
            mem_err     <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
          if (valid_in && mem_op) begin
            mem.mem_req   <= 1'b1;
            mem.mem_we    <= !is_load;
            mem.mem_addr  <= alu_result;
            mem.mem_wdata <= store_data;
            rd_q          <= rd_in;
            rw_q          <= reg_write_in;
            state         <= ST_REQ;
          end else if (valid_in) begin
            // mem_to_reg only moves when a write actually happens
            wb_en <= alu_wr;
            wb_rd <= rd_in;
            alu_q <= alu_result;
            if (alu_wr) mem_to_reg <= SEL_ALU;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/mem_wb_ctrl.md
Name: mem_wb_ctrl

Overview:
Sequences the MEM and writeback stages around a variable-latency data memory. It issues load and store requests using a req/ack handshake and stalls the upstream pipeline while a request is outstanding. It drives the mem_to_reg select and register-file write enable, and presents registered ALU and load data to the existing mem_to_reg mux. It sits between the EX/MEM pipeline register and the register file write port.

Parameters:
XLEN, 32, data and address width.
TIMEOUT, 16, number of cycles in REQ without mem_ack before the request is aborted (range 1..255).

Ports:
clk  in  1  system clock, rising-edge.
rst  in  1  synchronous reset, active-high.
valid_in  in  1  instruction present in MEM stage.
is_load  in  1  instruction is a load.
is_store  in  1  instruction is a store (is_load and is_store both high is treated as load).
reg_write_in  in  1  instruction writes rd.
rd_in  in  5  destination register.
alu_result  in  XLEN  ALU result; also the memory address for loads and stores.
store_data  in  XLEN  store write data.
mem_ack  in  1  memory completes the current request; for loads, mem_rdata is valid in the same cycle.
mem_rdata  in  XLEN  load data.
mem_req  out  1  memory request.
mem_we  out  1  1 = store, 0 = load.
mem_addr  out  XLEN  request address.
mem_wdata  out  XLEN  store data.
stall  out  1  upstream must hold its inputs.
mem_to_reg  out  1  0 = select alu_q, 1 = select ld_q.
alu_q  out  XLEN  registered ALU result.
ld_q  out  XLEN  registered load data.
wb_en  out  1  register-file write enable.
wb_rd  out  5  register-file write address.
mem_err  out  1  one-cycle pulse on timeout.

Behaviour:
- Reset: all outputs 0, state IDLE, timeout counter 0. Reset wins over every other event.
- Reset asserted in REQ: mem_req is low after that edge; the pending request is discarded and no writeback occurs.
- States: IDLE, REQ, WB.
- IDLE, valid_in with is_load or is_store:
  - Latch addr, wdata, we, rd and reg_write.
  - Go to REQ. mem_req is high starting the next cycle.
  - stall is high combinationally in the accept cycle and stays high through REQ.
- IDLE, valid_in with no memory op:
  - Next cycle: wb_en = reg_write_in and (rd_in != 0), wb_rd = rd_in, alu_q = alu_result, mem_to_reg = 0.
  - Latency 1; no stall; back-to-back ALU operations write back every cycle.
- IDLE, valid_in low: wb_en = 0 next cycle.
- REQ:
  - mem_req, mem_we, mem_addr and mem_wdata are held constant until mem_ack.
  - Timer increments each REQ cycle without mem_ack.
  - mem_ack on the first REQ cycle is legal.
- mem_ack on a load:
  - Capture ld_q = mem_rdata and go to WB.
  - mem_req is low next cycle; stall stays high in that cycle.
- mem_ack on a store:
  - Go to IDLE; mem_req and stall are low next cycle; no writeback.
- Timeout (timer == TIMEOUT-1 with no ack):
  - Drop mem_req, pulse mem_err for 1 cycle, go to IDLE, no writeback.
  - An ack arriving after mem_req has dropped is ignored.
- WB (one cycle):
  - wb_en = latched reg_write and (rd != 0); mem_to_reg = 1; wb_rd = latched rd; stall = 0.
  - Next state IDLE. A new valid_in in the WB cycle is accepted exactly as in IDLE.
- Load-to-writeback latency: accept cycle + REQ cycles + 1 WB cycle.
- mem_to_reg holds its last value whenever wb_en = 0.
- rd = 0 never asserts wb_en.

Decomposition:
- Shared package mem_wb_pkg:
  - State encodings ST_IDLE = 2'd0, ST_REQ = 2'd1, ST_WB = 2'd2.
  - Select constants SEL_ALU = 0, SEL_MEM = 1.
- One natural sub-module: req_timer. It is an 8-bit counter with clear and enable, and outputs expired when count == TIMEOUT-1.

Test Plan:
- rst = 1 for 2 cycles with valid_in and is_load high → all outputs 0, mem_req never asserted.
- ALU op, alu_result = 15, rd = 5, reg_write = 1 → next cycle wb_en = 1, wb_rd = 5, alu_q = 15, mem_to_reg = 0, stall = 0.
- Load, addr = 0x100, rd = 3, mem_ack after 3 REQ cycles with mem_rdata = 20:
  - mem_req high for exactly 3 cycles with mem_addr = 0x100 and mem_we = 0.
  - Then wb_en = 1, mem_to_reg = 1, ld_q = 20, wb_rd = 3.
  - stall is high from the accept cycle through the ack cycle.
- Store, addr = 0x40, data = 0xDEADBEEF, ack in the first REQ cycle → single-cycle mem_req with mem_we = 1, no wb_en, stall drops the following cycle.
- Load with no ack, TIMEOUT = 4 → mem_req high for 4 cycles, mem_err pulses once, no wb_en; a late ack is ignored; a following ALU op writes back normally.
- Edge cases:
  - Load with rd = 0 → no wb_en.
  - Reset in the second REQ cycle → mem_req is low after that edge, and a subsequent ALU op completes normally.
